// File: rtl/frame_ram_fetch_arbiter_pkg.sv
// Shared constants and pipeline tag type for the sprite-sheet frame RAM fetch path.
package frame_ram_pkg;
   localparam int SHEET_W = 2441;
   localparam int SHEET_H = 130;
   localparam int ADDR_W  = 19;
   localparam int X_W     = 12;
   localparam int Y_W     = 8;
   localparam int IDX_W   = 3;  // covers up to 8 requesters
   localparam logic [3:0] TRANSPARENT = 4'h0;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic             oob;
   } fetch_tag_t;
endpackage

// File: rtl/frame_ram_fetch_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index, one grant per cycle.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               grant_any
);
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      j         = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = IW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_any && req[j]) begin
            grant_any = 1'b1;
            grant_idx = j;
            grant[j]  = 1'b1;
         end
      end
      if (Reset) begin
         grant     = '0;
         grant_any = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)          rr_ptr <= IW'(NUM_REQ - 1);
      else if (grant_any) rr_ptr <= grant_idx;
   end
endmodule

// File: rtl/frame_ram_fetch_arbiter.sv
// Shares the frame RAM read port between sprite renderers; fixed 2-cycle response latency.
module frame_ram_fetch_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int SHEET_W = 2441,
   parameter  int SHEET_H = 130,
   parameter  int ADDR_W  = 19,
   parameter  int X_W     = 12,
   parameter  int Y_W     = 8,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0][X_W-1:0]   req_x,
   input  logic [NUM_REQ-1:0][Y_W-1:0]   req_y,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [ADDR_W-1:0]             read_address,
   input  logic [3:0]                    ram_data,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [3:0]                    rsp_data
);
   import frame_ram_pkg::*;

   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic               grant_any;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .Clk       (Clk),
      .Reset     (Reset),
      .req       (req_valid),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [ADDR_W-1:0] addr;
   logic              oob;

   assign x    = req_x[grant_idx];
   assign y    = req_y[grant_idx];
   assign addr = ADDR_W'(y) * ADDR_W'(SHEET_W) + ADDR_W'(x);
   assign oob  = (32'(x) >= SHEET_W) || (32'(y) >= SHEET_H);

   // tag_a rides with read_address, tag_b lines up with the RAM's registered data
   fetch_tag_t tag_a, tag_b;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         read_address <= '0;
         tag_a        <= '0;
         tag_b        <= '0;
      end else begin
         if (grant_any) read_address <= oob ? '0 : addr;
         tag_a <= '{valid: grant_any, idx: IDX_W'(grant_idx), oob: oob};
         tag_b <= tag_a;
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_data  = 4'h0;
      if (tag_b.valid) begin
         rsp_valid[tag_b.idx[IW-1:0]] = 1'b1;
         rsp_data = tag_b.oob ? TRANSPARENT : ram_data;
      end
   end
endmodule

// File: tb/tb_frame_ram_fetch_arbiter.sv
// Directed + randomised bench with a response scoreboard and reference arbiter/address model.
module tb_frame_ram_fetch_arbiter;
   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic [3:0]       req_valid = '0;
   logic [3:0][11:0] req_x = '0;
   logic [3:0][7:0]  req_y = '0;
   logic [3:0]       req_ready;
   logic [18:0]      read_address;
   logic [3:0]       ram_data = '0;
   logic [3:0]       rsp_valid;
   logic [3:0]       rsp_data;

   frame_ram_fetch_arbiter #(.NUM_REQ(4)) dut (
      .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready), .read_address(read_address), .ram_data(ram_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data)
   );

   always #5 Clk = ~Clk;

   function automatic logic [3:0] mem_f(int a);
      return 4'((a * 7 + 5) ^ (a >> 4));
   endfunction

   always @(posedge Clk) ram_data <= mem_f(int'(read_address));

   typedef struct { int due; int idx; logic [3:0] data; } exp_t;
   exp_t q[$];
   int   n_pass = 0, n_tot = 0;
   int   cyc = 0, mptr = 3, exp_ra = 0, last_g = -1;
   logic [3:0] pend = '0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tot++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   function automatic int pick(logic [3:0] v, int p);
      for (int k = 1; k <= 4; k++)
         if (v[2'((p + k) % 4)]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic tick();
      exp_t e;
      int   g, a, xx, yy;
      logic [3:0] erv, erd;
      bit   oob;
      @(negedge Clk);
      erv = '0; erd = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         erv = 4'(1 << e.idx);
         erd = e.data;
      end
      chk("rsp_valid", rsp_valid, erv);
      chk("rsp_data", rsp_data, erd);
      chk("read_address", read_address, exp_ra);
      g = Reset ? -1 : pick(req_valid, mptr);
      chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      if (Reset) begin
         mptr = 3; exp_ra = 0; q.delete();
      end else if (g >= 0) begin
         xx = int'(req_x[2'(g)]); yy = int'(req_y[2'(g)]);
         oob = (xx >= 2441) || (yy >= 130);
         a = oob ? 0 : yy * 2441 + xx;
         exp_ra = a;
         q.push_back('{due: cyc + 2, idx: g, data: oob ? 4'h0 : mem_f(a)});
         mptr = g;
      end
      last_g = g;
      @(posedge Clk);
      cyc++;
      #1;
   endtask

   initial begin
      @(posedge Clk); #1;
      // reset state
      tick(); tick();
      chk("rst_ra", read_address, 0);
      chk("rst_rsp", rsp_valid, 0);
      Reset = 1'b0;

      // single request from requester 2
      req_valid = 4'b0100; req_x[2] = 12'd10; req_y[2] = 8'd3;
      tick();
      chk("single_ra", read_address, 7333);
      req_valid = '0;
      tick();
      chk("single_rv", rsp_valid, 4'b0100);
      chk("single_rd", rsp_data, mem_f(7333));
      tick();

      // all four valid from reset
      Reset = 1'b1; tick(); Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_x[i] = 12'(100 * i + 1); req_y[i] = 8'(20 * i);
      end
      req_valid = 4'b1111;
      #1 chk("all_first", req_ready, 4'b0001);
      for (int i = 0; i < 12; i++) tick();
      req_valid = '0; tick(); tick();

      // corner and out-of-bounds coordinates
      req_valid = 4'b0010; req_x[1] = 12'd2440; req_y[1] = 8'd129;
      tick();
      chk("corner_ra", read_address, 317329);
      req_x[1] = 12'd2441; req_y[1] = 8'd0;
      tick();
      chk("oobx_ra", read_address, 0);
      chk("corner_rd", rsp_data, mem_f(317329));
      req_x[1] = 12'd0; req_y[1] = 8'd130;
      tick();
      chk("oobx_rv", rsp_valid, 4'b0010);
      chk("oobx_rd", rsp_data, 0);
      req_valid = '0;
      tick();
      chk("ooby_rv", rsp_valid, 4'b0010);
      chk("ooby_rd", rsp_data, 0);
      tick(); tick();

      // requesters 1 and 3, then 1 drops, idle, 1 returns
      Reset = 1'b1; tick(); Reset = 1'b0;
      req_x[1] = 12'd7; req_y[1] = 8'd2; req_x[3] = 12'd9; req_y[3] = 8'd4;
      req_valid = 4'b1010;
      #1 chk("rr_1first", req_ready, 4'b0010);
      tick();
      req_valid = 4'b1000;
      #1 chk("rr_3", req_ready, 4'b1000);
      tick(); tick(); tick();
      req_valid = '0; tick(); tick();
      req_valid = 4'b1010;
      #1 chk("rr_1again", req_ready, 4'b0010);
      tick();
      req_valid = '0; tick(); tick(); tick();

      // reset while two requests are in flight
      req_valid = 4'b0001; req_x[0] = 12'd5; req_y[0] = 8'd1;
      tick();
      req_valid = 4'b0010;
      tick();
      Reset = 1'b1; req_valid = 4'b1111;
      #1 chk("rst_ready0", req_ready, 0);
      tick();
      Reset = 1'b0; req_valid = '0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_norsp", rsp_valid, 0);
         chk("rst_ra0", read_address, 0);
         tick();
      end
      req_valid = 4'b1111;
      #1 chk("rst_req0", req_ready, 4'b0001);
      tick();
      req_valid = '0; tick(); tick(); tick();

      // randomised traffic; coordinates held until accepted
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
               pend[i]  = 1'b1;
               req_x[i] = 12'($urandom_range(0, 2450));
               req_y[i] = 8'($urandom_range(0, 135));
            end
         end
         req_valid = pend;
         tick();
         if (last_g >= 0) pend[2'(last_g)] = 1'b0;
      end
      req_valid = '0;
      tick(); tick(); tick();
      chk("drain", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
